// File: rtl/m_play_controller_pkg.sv
// m_play_controller_pkg: button codes, FSM state encoding and input helpers shared by the controller
package m_play_controller_pkg;
  localparam logic [3:0] IN_INC = 4'b0001;
  localparam logic [3:0] IN_DEC = 4'b0010;
  localparam logic [3:0] IN_OK  = 4'b0100;
  localparam logic [3:0] IN_NEW = 4'b1000;
  typedef enum logic [1:0] {
    ST_TURN      = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/m_play_controller_column_dropper.sv
// m_column_dropper: combinational piece drop into one column of a field, with per-column fill counts
module m_column_dropper #(
  parameter  int COLS  = 7,
  parameter  int ROWS  = 6,
  localparam int CNT_W = $clog2(ROWS + 1),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic [COLS*ROWS-1:0]  i_field,
  input  logic [COLS*CNT_W-1:0] i_counts,
  input  logic [COL_W-1:0]      i_col,
  output logic                  o_valid,
  output logic [COLS*ROWS-1:0]  o_field,
  output logic [COLS*CNT_W-1:0] o_counts
);
  logic [CNT_W-1:0] cnt [COLS];
  logic [CNT_W-1:0] sel;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign cnt[c] = i_counts[c*CNT_W +: CNT_W];
    assign o_counts[c*CNT_W +: CNT_W] = cnt[c] + CNT_W'(o_valid && i_col == COL_W'(c));
    // The piece lands on the lowest empty row, which is the column's fill count
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign o_field[r*COLS+c] = i_field[r*COLS+c] | (o_valid && i_col == COL_W'(c) && sel == CNT_W'(r));
    end
  end
  assign sel     = cnt[i_col];
  assign o_valid = sel < CNT_W'(ROWS);
endmodule

// File: rtl/m_play_controller.sv
// m_play_controller: two-player drop-piece game controller with cursor, settle delay and game-over
module m_play_controller
  import m_play_controller_pkg::*;
#(
  parameter  int COLS          = 7,
  parameter  int ROWS          = 6,
  parameter  int SETTLE_CYCLES = 256,
  localparam int CNT_W         = $clog2(ROWS + 1),
  localparam int COL_W         = $clog2(COLS),
  localparam int MC_W          = $clog2(COLS*ROWS + 1),
  localparam int SC_W          = $clog2(SETTLE_CYCLES) + 1
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic [3:0]           w_user_input,
  output logic [COL_W-1:0]     o_selecting_col,
  output logic [COLS*ROWS-1:0] o_red_field,
  output logic [COLS*ROWS-1:0] o_blue_field,
  output logic                 o_turn,
  output logic                 o_busy,
  output logic                 o_reject,
  output logic [MC_W-1:0]      o_move_count,
  output logic                 o_game_over
);
  localparam int N = COLS * ROWS;
  state_e                 state_q, state_d;
  logic [3:0]             prev_q, code;
  logic [COL_W-1:0]       cursor_q, cursor_d, pend_q, pend_d;
  logic [SC_W-1:0]        settle_q, settle_d;
  logic [N-1:0]           red_q, red_d, blue_q, blue_d, drop_field;
  logic [COLS*CNT_W-1:0]  counts_q, counts_d, drop_counts;
  logic [MC_W-1:0]        moves_q, moves_d;
  logic                   turn_q, turn_d, reject_q, reject_d, drop_valid;
  // One dropper serves both the full-column check on the cursor and the commit of the pending column
  m_column_dropper #(.COLS(COLS), .ROWS(ROWS)) u_drop (
    .i_field  (turn_q ? blue_q : red_q),
    .i_counts (counts_q),
    .i_col    (state_q == ST_SETTLE ? pend_q : cursor_q),
    .o_valid  (drop_valid),
    .o_field  (drop_field),
    .o_counts (drop_counts)
  );
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    red_d    = red_q;
    blue_d   = blue_q;
    counts_d = counts_q;
    moves_d  = moves_q;
    turn_d   = turn_q;
    reject_d = 1'b0;
    code     = (is_onehot(w_user_input) && prev_q == 4'd0) ? w_user_input : 4'd0;
    if (state_q == ST_SETTLE) begin
      settle_d = settle_q + SC_W'(1);
      if (settle_q == SC_W'(SETTLE_CYCLES - 1)) begin
        red_d    = turn_q ? red_q : drop_field;
        blue_d   = turn_q ? drop_field : blue_q;
        counts_d = drop_counts;
        moves_d  = moves_q + MC_W'(1);
        turn_d   = ~turn_q;
        state_d  = (moves_q + MC_W'(1) == MC_W'(N)) ? ST_GAME_OVER : ST_TURN;
      end
    end else if (code == IN_NEW) begin
      state_d  = ST_TURN;
      cursor_d = '0;
      red_d    = '0;
      blue_d   = '0;
      counts_d = '0;
      moves_d  = '0;
      turn_d   = 1'b0;
    end else if (state_q == ST_TURN) begin
      cursor_d = code == IN_INC ? (cursor_q == COL_W'(COLS - 1) ? '0 : cursor_q + COL_W'(1)) :
                 code == IN_DEC ? (cursor_q == '0 ? COL_W'(COLS - 1) : cursor_q - COL_W'(1)) : cursor_q;
      if (code == IN_OK) begin
        reject_d = !drop_valid;
        pend_d   = cursor_q;
        settle_d = '0;
        state_d  = drop_valid ? ST_SETTLE : ST_TURN;
      end
    end
  end
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q  <= ST_TURN;
      prev_q   <= '0;
      cursor_q <= '0;
      pend_q   <= '0;
      settle_q <= '0;
      red_q    <= '0;
      blue_q   <= '0;
      counts_q <= '0;
      moves_q  <= '0;
      turn_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= w_user_input;
      cursor_q <= cursor_d;
      pend_q   <= pend_d;
      settle_q <= settle_d;
      red_q    <= red_d;
      blue_q   <= blue_d;
      counts_q <= counts_d;
      moves_q  <= moves_d;
      turn_q   <= turn_d;
      reject_q <= reject_d;
    end
  end
  assign o_selecting_col = cursor_q;
  assign o_red_field     = red_q;
  assign o_blue_field    = blue_q;
  assign o_turn          = turn_q;
  assign o_reject        = reject_q;
  assign o_move_count    = moves_q;
  assign o_busy          = state_q == ST_SETTLE;
  assign o_game_over     = state_q == ST_GAME_OVER;
endmodule
